mdu: RTL and testbench

Parametrised multiply/divide unit: the multi-cycle successor of the combinational ALU in the MIPS datapath. It executes signed/unsigned multiply and divide over a configurable operand width with configurable fixed latencies, and holds the HI/LO result registers. It sits beside the ALU in the execute stage, and its busy output drives the pipeline stall logic.

---
 rtl/mdu.sv | 206 ++++++++++++++++++++
 tb/tb_mdu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multi-cycle multiply/divide unit with HI/LO result registers.
//
// Executes MULT/MULTU (and, when the MDU_DIV_EN macro is defined, DIV/DIVU)
// with fixed latencies, and services MTHI/MTLO writes while idle. The busy
// output is a pure register (state == RUN) so the pipeline stall logic never
// sees a combinational path from start.
//
// Configuration macro:
//   MDU_DIV_EN  defined   -> DIV/DIVU implemented (DIV_CYCLES latency).
//               undefined -> no divider; DIV/DIVU behave like MDUOp 000.
//
// Parameters:
//   WIDTH       operand and HI/LO width
//   MUL_CYCLES  busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES  busy cycles for DIV/DIVU (>= 1)
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset
//   start  in   request strobe, MDUOp valid while high
//   MDUOp  in   3-bit operation code
//   SA     in   rs operand (multiplicand / dividend / MTHI-MTLO source)
//   SB     in   rt operand (multiplier / divisor)
//   busy   out  operation in flight
//   HI     out  HI register (product high half / remainder)
//   LO     out  LO register (product low half / quotient)
// -----------------------------------------------------------------------------
module mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] SA,
  input  logic [WIDTH-1:0] SB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  // ---------------------------------------------------------------------------
  // Multiplier: operands are extended to 2*WIDTH (sign- or zero-extended by
  // op) so a single truncated multiply yields the exact full-width product
  // for both signed and unsigned forms. Inputs are the latched operands only.
  // ---------------------------------------------------------------------------
  logic               mul_sgn;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mul_sgn = (op_q == OP_MULT);
    a_ext   = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
    b_ext   = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
    prod    = a_ext * b_ext;
  end

`ifdef MDU_DIV_EN
  // ---------------------------------------------------------------------------
  // Divider: sign-magnitude around an unsigned divide. The quotient is
  // negated when operand signs differ (truncation toward zero) and the
  // remainder takes the dividend's sign. The most-negative / -1 case falls
  // out naturally: its magnitude 2^(WIDTH-1) is representable unsigned, and
  // the unsigned quotient re-reads as the most-negative value with rem 0.
  // ---------------------------------------------------------------------------
  logic             div_sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  always_comb begin
    div_sgn = (op_q == OP_DIV);
    a_neg   = div_sgn & a_q[WIDTH-1];
    b_neg   = div_sgn & b_q[WIDTH-1];
    a_mag   = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag   = b_neg ? (~b_q + 1'b1) : b_q;
    // Divide-by-zero results are discarded; force a defined value anyway.
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end else begin
      q_mag = '0;
      r_mag = '0;
    end
    quo = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem = a_neg ? (~r_mag + 1'b1) : r_mag;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (MDUOp)
            OP_MULT, OP_MULTU: begin
              a_d     = SA;
              b_d     = SB;
              op_d    = MDUOp;
              cnt_d   = CNT_W'(MUL_CYCLES);
              state_d = RUN;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              a_d     = SA;
              b_d     = SB;
              op_d    = MDUOp;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
`endif
            OP_MTHI: hi_d = SA;
            OP_MTLO: lo_d = SA;
            default: ;
          endcase
        end
      end

      RUN: begin
        // start is ignored here; the issuing stage is stalled by busy.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
            {hi_d, lo_d} = prod;
          end
`ifdef MDU_DIV_EN
          else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu -- directed self-checking bench for mdu (WIDTH=32, default latencies).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mdu;

  localparam int W    = 32;
  localparam int NMUL = 5;
  localparam int NDIV = 10;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   MDUOp;
  logic [W-1:0] SA;
  logic [W-1:0] SB;
  logic         busy;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int checks   = 0;
  int failures = 0;

  mdu #(
    .WIDTH     (W),
    .MUL_CYCLES(NMUL),
    .DIV_CYCLES(NDIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDUOp(MDUOp),
    .SA   (SA),
    .SB   (SB),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at the current falling edge, scramble operands while busy,
  // count busy cycles (bounded) and check HI/LO hold until completion, then
  // check latency and final HI/LO. Returns at the falling edge after busy
  // drops, so calls can be chained back-to-back.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int n,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input string name);
    logic [W-1:0] h0;
    logic [W-1:0] l0;
    int           cyc;
    h0    = HI;
    l0    = LO;
    start = 1'b1;
    MDUOp = op;
    SA    = a;
    SB    = b;
    @(negedge clk);
    start = 1'b0;
    MDUOp = OP_NONE;
    SA    = $urandom;
    SB    = $urandom;
    cyc   = 0;
    while (busy === 1'b1 && cyc < 100) begin
      checks++;
      if (HI !== h0 || LO !== l0) begin
        failures++;
        $display("FAIL %s_hold: HI=%08h LO=%08h during busy, required HI=%08h LO=%08h",
                 name, HI, LO, h0, l0);
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== n) begin
      failures++;
      $display("FAIL %s_busy: busy cycles=%0d required=%0d", name, cyc, n);
    end
    checks++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      failures++;
      $display("FAIL %s_result: HI=%08h LO=%08h required HI=%08h LO=%08h",
               name, HI, LO, exp_hi, exp_lo);
    end
    $display("txn %-10s op=%03b SA=%08h SB=%08h busy_cycles=%0d HI=%08h LO=%08h",
             name, op, a, b, cyc, HI, LO);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    MDUOp = OP_NONE;
    SA    = '0;
    SB    = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || HI !== '0 || LO !== '0) begin
      failures++;
      $display("FAIL reset_values: busy=%b HI=%08h LO=%08h required busy=0 HI=0 LO=0",
               busy, HI, LO);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("txn reset      busy=%b HI=%08h LO=%08h", busy, HI, LO);
  endtask

  task automatic test_mult();
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, NMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, NMUL, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, NMUL, 32'h4000_0000, 32'h0000_0000, "mult_min");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NMUL, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1;
    MDUOp = OP_MTLO;
    SA    = 32'h0000_ABCD;
    @(negedge clk);
    start = 1'b0;
    MDUOp = OP_NONE;
    checks++;
    if (LO !== 32'h0000_ABCD || busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: LO=%08h busy=%b required LO=0000abcd busy=0", LO, busy);
    end
    start = 1'b1;
    MDUOp = OP_MTHI;
    SA    = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0;
    MDUOp = OP_NONE;
    checks++;
    if (HI !== 32'h0000_0055 || LO !== 32'h0000_ABCD || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi: HI=%08h LO=%08h busy=%b required HI=00000055 LO=0000abcd busy=0",
               HI, LO, busy);
    end
    $display("txn mthi_mtlo  HI=%08h LO=%08h busy=%b", HI, LO, busy);
  endtask

  task automatic test_interlock();
    int cyc;
    start = 1'b1;
    MDUOp = OP_MULT;
    SA    = 32'd7;
    SB    = 32'd6;
    @(negedge clk);
    // MTHI presented for two cycles while the multiply runs.
    MDUOp = OP_MTHI;
    SA    = 32'h0000_1234;
    repeat (2) @(negedge clk);
    start = 1'b0;
    MDUOp = OP_NONE;
    checks++;
    if (HI !== 32'h0000_0055) begin
      failures++;
      $display("FAIL interlock_mthi: HI=%08h during busy required 00000055", HI);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (HI !== 32'h0000_0000 || LO !== 32'h0000_002A || cyc !== NMUL - 2) begin
      failures++;
      $display("FAIL interlock_result: HI=%08h LO=%08h tail=%0d required HI=0 LO=2a tail=%0d",
               HI, LO, cyc, NMUL - 2);
    end
    $display("txn interlock  HI=%08h LO=%08h", HI, LO);
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, NDIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, NDIV, 32'h0000_0001, 32'hFFFF_FFFD, "div_negb");
    run_op(OP_DIVU, 32'd100,       32'd7,         NDIV, 32'h0000_0002, 32'h0000_000E, "divu");
    run_op(OP_DIVU, 32'd7,         32'd0,         NDIV, 32'h0000_0002, 32'h0000_000E, "divu_zero");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, NDIV, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, NDIV, 32'h0000_0001, 32'h7FFF_FFFC, "divu_big");
  endtask
`else
  task automatic test_no_div();
    logic [W-1:0] h0;
    logic [W-1:0] l0;
    h0 = HI;
    l0 = LO;
    run_op(OP_DIVU, 32'd9, 32'd3, 0, h0, l0, "divu_off");
    run_op(OP_DIV,  32'd9, 32'd3, 0, h0, l0, "div_off");
    repeat (NDIV + 2) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL no_div_busy: busy=%b required 0", busy);
      end
      @(negedge clk);
    end
    run_op(OP_MULT, 32'd9, 32'd3, NMUL, 32'h0000_0000, 32'h0000_001B, "mult_9x3");
  endtask
`endif

  task automatic test_back_to_back();
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, NMUL, 32'h0000_0001, 32'h0000_0000, "b2b_1");
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, NMUL, 32'h0000_0000, 32'h0000_0001, "b2b_2");
    run_op(OP_MULT,  32'h0000_1234, 32'hFFFF_FFFF, NMUL, 32'hFFFF_FFFF, 32'hFFFF_EDCC, "b2b_3");
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    MDUOp = OP_MULT;
    SA    = 32'd7;
    SB    = 32'd6;
    @(negedge clk);
    start = 1'b0;
    MDUOp = OP_NONE;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || HI !== '0 || LO !== '0) begin
      failures++;
      $display("FAIL reset_midrun_now: busy=%b HI=%08h LO=%08h required busy=0 HI=0 LO=0",
               busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (NMUL) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || HI !== '0 || LO !== '0) begin
      failures++;
      $display("FAIL reset_midrun_after: busy=%b HI=%08h LO=%08h required busy=0 HI=0 LO=0",
               busy, HI, LO);
    end
    $display("txn reset_mid  busy=%b HI=%08h LO=%08h", busy, HI, LO);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mthi_mtlo();
    test_interlock();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_no_div();
`endif
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
